// File: rtl/seven_seg_scan.sv
// seven_seg_scan: drives a 4-digit common-anode multiplexed 7-segment display for a digital
// clock. It shows HH:MM or MM:SS, and the field being edited blinks. All outputs are
// registered, and only one scan digit is active at a time.
//
// Parameters
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   BLINK_DIV    clk cycles per blink phase toggle (>= 2)
//
// Ports
//   clk        system clock, posedge
//   rst_n      asynchronous active-low reset
//   h2, h1     hour tens/ones BCD
//   m2, m1     minute tens/ones BCD
//   s2, s1     second tens/ones BCD
//   show_sec   0: HH:MM, 1: MM:SS
//   pos        edit cursor, 0 = minute field, 1 = hour field
//   edit_en    blink the field selected by pos
//   alarm_hit  light dp on digit 0
//   an         anode enables, active low, an[0] = rightmost digit
//   seg        segments {g,f,e,d,c,b,a}, active low
//   dp         decimal point, active low
module seven_seg_scan #(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned BLINK_DIV   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] h2,
  input  logic [3:0] h1,
  input  logic [3:0] m2,
  input  logic [3:0] m1,
  input  logic [3:0] s2,
  input  logic [3:0] s1,
  input  logic       show_sec,
  input  logic       pos,
  input  logic       edit_en,
  input  logic       alarm_hit,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BlkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RefW-1:0] RefMax = RefW'(REFRESH_DIV - 1);
  localparam logic [BlkW-1:0] BlkMax = BlkW'(BLINK_DIV - 1);

  logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
  logic [BlkW-1:0] blk_cnt_q, blk_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            blink_ph_q, blink_ph_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            ref_wrap, blk_wrap;
  logic [3:0]      digit;
  logic            edited, blank;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Slot and blink timers; both wraps may land in the same cycle.
  always_comb begin
    ref_wrap   = (ref_cnt_q == RefMax);
    blk_wrap   = (blk_cnt_q == BlkMax);
    ref_cnt_d  = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    blk_cnt_d  = blk_wrap ? '0 : blk_cnt_q + 1'b1;
    idx_d      = ref_wrap ? idx_q + 2'd1 : idx_q;
    blink_ph_d = blk_wrap ? ~blink_ph_q : blink_ph_q;
  end

  // Digit mux, edit blanking and output decode for the current slot.
  always_comb begin
    digit  = 4'h0;
    edited = 1'b0;
    unique case (idx_q)
      2'd3: begin
        digit  = show_sec ? m2 : h2;
        edited = pos ^ show_sec;
      end
      2'd2: begin
        digit  = show_sec ? m1 : h1;
        edited = pos ^ show_sec;
      end
      2'd1: begin
        digit  = show_sec ? s2 : m2;
        edited = ~pos & ~show_sec;
      end
      default: begin
        digit  = show_sec ? s1 : m1;
        edited = ~pos & ~show_sec;
      end
    endcase

    blank = edit_en & ~blink_ph_q & edited;

    an_d  = ~(4'b0001 << idx_q);
    seg_d = decode(digit);
    dp_d  = 1'b1;
    if (idx_q == 2'd2) begin
      dp_d = ~blink_ph_q;   // colon pulse
    end else if (idx_q == 2'd0) begin
      dp_d = ~alarm_hit;
    end
    if (blank) begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q  <= '0;
      blk_cnt_q  <= '0;
      idx_q      <= 2'd0;
      blink_ph_q <= 1'b1;
      an_q       <= 4'b1111;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      idx_q      <= idx_d;
      blink_ph_q <= blink_ph_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
module tb_seven_seg_scan;

  localparam int unsigned RDiv = 4;
  localparam int unsigned BDiv = 16;
  localparam int          RunLen = 37;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] h2, h1, m2, m1, s2, s1;
  logic       show_sec, pos, edit_en, alarm_hit;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seven_seg_scan #(
    .REFRESH_DIV(RDiv),
    .BLINK_DIV  (BDiv)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .h2       (h2),
    .h1       (h1),
    .m2       (m2),
    .m1       (m1),
    .s2       (s2),
    .s1       (s1),
    .show_sec (show_sec),
    .pos      (pos),
    .edit_en  (edit_en),
    .alarm_hit(alarm_hit),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] h2, h1, m2, m1, s2, s1;
    logic       ss, ps, ed, al;
    logic [6:0] sg [4];   // expected seg per digit index (0 = rightmost)
    logic [3:0] mask;     // digits dark during blink_ph=0 when editing
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  vec_t vecs [8];
  out_t sb [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  function automatic vec_t mk(input logic [3:0] a3, a2, a1, a0, b1, b0,
                              input logic ss, ps, ed, al,
                              input logic [6:0] g3, g2, g1, g0,
                              input logic [3:0] mask);
    vec_t v;
    v.h2 = a3; v.h1 = a2; v.m2 = a1; v.m1 = a0; v.s2 = b1; v.s1 = b0;
    v.ss = ss; v.ps = ps; v.ed = ed; v.al = al;
    v.sg[3] = g3; v.sg[2] = g2; v.sg[1] = g1; v.sg[0] = g0;
    v.mask = mask;
    return v;
  endfunction

  // Expected pins after the k-th clock edge since reset release.
  function automatic out_t exp_out(input int k, input vec_t v);
    out_t o;
    int   idx;
    logic ph;
    idx = ((k - 1) / RDiv) % 4;
    ph  = (((k - 1) / BDiv) % 2) == 0;
    o.an  = ~(4'b0001 << idx);
    o.seg = v.sg[idx];
    o.dp  = (idx == 2) ? ~ph : (idx == 0) ? ~v.al : 1'b1;
    if (v.ed && !ph && v.mask[idx]) begin
      o.an  = 4'hF;
      o.seg = 7'h7F;
      o.dp  = 1'b1;
    end
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    total++;
    if ({an, seg, dp} !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, cyc, an, seg, dp, exp.an, exp.seg, exp.dp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input vec_t v, input string name);
    out_t e;
    h2 = v.h2; h1 = v.h1; m2 = v.m2; m1 = v.m1; s2 = v.s2; s1 = v.s1;
    show_sec = v.ss; pos = v.ps; edit_en = v.ed; alarm_hit = v.al;
    cyc++;
    sb.push_back(exp_out(cyc, v));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check(name, e);
    end
    @(negedge clk);
  endtask

  localparam out_t OffOut = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

  initial begin
    //          h2    h1    m2    m1    s2    s1    ss pos ed al
    vecs[0] = mk(4'd1, 4'd2, 4'd5, 4'd8, 4'd3, 4'd3, 0, 0, 0, 0,
                 7'b1111001, 7'b0100100, 7'b0010010, 7'b0000000, 4'b0000);
    vecs[1] = mk(4'd9, 4'd9, 4'd5, 4'd8, 4'd0, 4'd7, 1, 0, 0, 0,
                 7'b0010010, 7'b0000000, 7'b1000000, 7'b1111000, 4'b0000);
    vecs[2] = mk(4'd1, 4'd2, 4'd5, 4'd8, 4'd3, 4'd3, 0, 1, 1, 0,
                 7'b1111001, 7'b0100100, 7'b0010010, 7'b0000000, 4'b1100);
    vecs[3] = mk(4'd9, 4'd9, 4'd5, 4'd8, 4'd0, 4'd7, 1, 1, 1, 0,
                 7'b0010010, 7'b0000000, 7'b1000000, 7'b1111000, 4'b0000);
    vecs[4] = mk(4'd1, 4'd2, 4'd5, 4'd8, 4'd3, 4'd3, 0, 0, 1, 0,
                 7'b1111001, 7'b0100100, 7'b0010010, 7'b0000000, 4'b0011);
    vecs[5] = mk(4'd9, 4'd9, 4'd5, 4'd8, 4'd0, 4'd7, 1, 0, 1, 0,
                 7'b0010010, 7'b0000000, 7'b1000000, 7'b1111000, 4'b1100);
    vecs[6] = mk(4'd0, 4'd3, 4'd4, 4'hA, 4'd0, 4'd0, 0, 0, 0, 1,
                 7'b1000000, 7'b0110000, 7'b0011001, 7'b1111111, 4'b0000);
    vecs[7] = mk(4'd2, 4'd2, 4'd6, 4'd9, 4'hF, 4'd6, 1, 0, 0, 1,
                 7'b0000010, 7'b0010000, 7'b1111111, 7'b0000010, 4'b0000);

    h2 = 0; h1 = 0; m2 = 0; m1 = 0; s2 = 0; s1 = 0;
    show_sec = 0; pos = 0; edit_en = 0; alarm_hit = 0;

    // Reset held with clock running.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", OffOut);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // Vector table; changes land mid-slot since RunLen is not a slot multiple.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < RunLen; i++) step(vecs[v], $sformatf("vec%0d", v));
    end

    // Reset asserted mid-slot at idx=2.
    for (int i = 0; i < 20; i++) begin
      if ((((cyc / RDiv) % 4) == 2) && ((cyc % RDiv) == 1)) break;
      step(vecs[0], "pre_reset");
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", OffOut);
    repeat (2) @(posedge clk);
    #1;
    check("reset_mid_hold", OffOut);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < RunLen; i++) step(vecs[2], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
